// File: rtl/vpu_pkg.sv
// Shared types and sizing for the vector operand fetch path.
package vpu_pkg;

    localparam int NUM_BANKS = 8;
    localparam int DATA_W    = 32;
    localparam int ROW_AW    = 7;
    localparam int VLEN_W    = 11;
    localparam int BUF_DEPTH = 2;
    localparam int ROW_W     = NUM_BANKS * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fsm_state_t;

    // One operand beat as presented to the lanes.
    typedef struct packed {
        logic [ROW_W-1:0]     a;
        logic [ROW_W-1:0]     b;
        logic [NUM_BANKS-1:0] mask;
        logic                 last;
    } beat_t;

endpackage

// File: rtl/vpu_beat_fifo.sv
// Two-entry fall-through FIFO of operand beats. When empty, a push is
// visible at the head in the same cycle, so it can be popped straight through.
module vpu_beat_fifo
    import vpu_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output logic       head_valid,
    output beat_t      head_beat,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    beat_t mem [0:1];
    logic  wr_ptr;
    logic  rd_ptr;
    logic  do_pop;
    logic  bypass;
    logic  do_write;
    logic  mem_pop;

    // Head selection, bypass and occupancy decisions.
    always_comb begin
        empty      = (count == 2'd0);
        full       = (count == 2'd2);
        head_valid = !empty || push;
        head_beat  = empty ? push_beat : mem[rd_ptr];
        do_pop     = pop && head_valid;
        bypass     = empty && push && do_pop;
        mem_pop    = do_pop && !empty;
        do_write   = push && !bypass && (!full || mem_pop);
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_write) wr_ptr <= ~wr_ptr;
            if (mem_pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_write) - 2'(mem_pop);
        end
    end

    // Beat storage; contents are only meaningful under count.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= push_beat;
    end

endmodule

// File: rtl/vrf_operand_fetch.sv
// Walks the vector register file row by row for one vector-operand command
// and streams paired A/B beats to the lanes with a tail lane mask.
module vrf_operand_fetch #(
    parameter int NUM_BANKS = vpu_pkg::NUM_BANKS,
    parameter int DATA_W    = vpu_pkg::DATA_W,
    parameter int ROW_AW    = vpu_pkg::ROW_AW,
    parameter int VLEN_W    = vpu_pkg::VLEN_W,
    parameter int BUF_DEPTH = vpu_pkg::BUF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ROW_AW-1:0]           cmd_src1_row,
    input  logic [ROW_AW-1:0]           cmd_src2_row,
    input  logic [VLEN_W-1:0]           cmd_vlen,
    output logic                        vrf_rd_en,
    output logic [ROW_AW-1:0]           vrf_rd_addr1,
    output logic [ROW_AW-1:0]           vrf_rd_addr2,
    input  logic [NUM_BANKS*DATA_W-1:0] vrf_rd_data1,
    input  logic [NUM_BANKS*DATA_W-1:0] vrf_rd_data2,
    output logic                        op_valid,
    input  logic                        op_ready,
    output logic [NUM_BANKS*DATA_W-1:0] op_a,
    output logic [NUM_BANKS*DATA_W-1:0] op_b,
    output logic [NUM_BANKS-1:0]        op_lane_mask,
    output logic                        op_last,
    output logic                        busy
);

    import vpu_pkg::*;

    localparam int LANE_W     = $clog2(NUM_BANKS);
    localparam int BEAT_CNT_W = VLEN_W - LANE_W + 1;

    // Beats needed to cover vlen elements (ceiling division by lane count).
    function automatic logic [BEAT_CNT_W-1:0] beat_count(input logic [VLEN_W-1:0] v);
        logic [VLEN_W:0] t;
        t = {1'b0, v} + (VLEN_W+1)'(NUM_BANKS - 1);
        return BEAT_CNT_W'(t >> LANE_W);
    endfunction

    // Live-lane mask of the final beat; a zero remainder means a full beat.
    function automatic logic [NUM_BANKS-1:0] tail_mask(input logic [LANE_W-1:0] r);
        logic [NUM_BANKS-1:0] m;
        m = '1;
        if (r != '0) m = ~({NUM_BANKS{1'b1}} << r);
        return m;
    endfunction

    fsm_state_t              state;
    fsm_state_t              state_nx;
    logic [ROW_AW-1:0]       row1;
    logic [ROW_AW-1:0]       row2;
    logic [BEAT_CNT_W-1:0]   beats_left;
    logic [LANE_W-1:0]       rem;
    logic                    issue;
    logic                    last_issue;
    logic                    pop;
    logic [2:0]              occupancy;
    logic                    vld_p1;
    logic                    last_p1;
    logic [NUM_BANKS-1:0]    mask_p1;
    beat_t                   push_beat;
    beat_t                   head_beat;
    logic                    head_valid;
    logic [1:0]              fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;

    vpu_beat_fifo u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (vld_p1),
        .push_beat  (push_beat),
        .pop        (pop),
        .head_valid (head_valid),
        .head_beat  (head_beat),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Credit check, FSM next state and control outputs.
    always_comb begin
        pop        = head_valid && op_ready;
        // Buffered plus in-flight beats after this cycle's pop must leave room.
        occupancy  = {1'b0, fifo_count} + 3'(vld_p1) - 3'(pop);
        issue      = (state == FETCH) && (occupancy < 3'(BUF_DEPTH))
                     && !(fifo_full && !pop);
        last_issue = issue && (beats_left == BEAT_CNT_W'(1));
        state_nx   = state;
        cmd_ready  = 1'b0;
        busy       = (state != IDLE);
        vrf_rd_en  = issue;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_vlen != '0)) state_nx = FETCH;
            end
            FETCH: begin
                if (last_issue) state_nx = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty && !vld_p1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Assemble the beat arriving from the VRF and drive the lane outputs.
    always_comb begin
        push_beat.a    = vrf_rd_data1;
        push_beat.b    = vrf_rd_data2;
        push_beat.mask = mask_p1;
        push_beat.last = last_p1;
        vrf_rd_addr1   = row1;
        vrf_rd_addr2   = row2;
        op_valid       = head_valid;
        op_a           = head_valid ? head_beat.a    : '0;
        op_b           = head_valid ? head_beat.b    : '0;
        op_lane_mask   = head_valid ? head_beat.mask : '0;
        op_last        = head_valid ? head_beat.last : 1'b0;
    end

    // Control state: FSM, row walkers, beat counter and read-in-flight flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            row1       <= '0;
            row2       <= '0;
            beats_left <= '0;
            rem        <= '0;
            vld_p1     <= 1'b0;
        end else begin
            state  <= state_nx;
            vld_p1 <= issue;
            if (state == IDLE && cmd_valid) begin
                row1       <= cmd_src1_row;
                row2       <= cmd_src2_row;
                beats_left <= beat_count(cmd_vlen);
                rem        <= cmd_vlen[LANE_W-1:0];
            end else if (issue) begin
                row1       <= row1 + ROW_AW'(1);
                row2       <= row2 + ROW_AW'(1);
                beats_left <= beats_left - BEAT_CNT_W'(1);
            end
        end
    end

    // ---- stage p1: sideband travelling with the outstanding read ----
    always_ff @(posedge clk) begin
        if (issue) begin
            last_p1 <= last_issue;
            mask_p1 <= last_issue ? tail_mask(rem) : '1;
        end
    end

endmodule

// File: tb/tb_vrf_operand_fetch.sv
// Directed bench for vrf_operand_fetch with a 1-cycle-latency VRF model.
module tb_vrf_operand_fetch;

    localparam int NB = 8;
    localparam int DW = 32;
    localparam int RW = NB * DW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [6:0]    cmd_src1_row;
    logic [6:0]    cmd_src2_row;
    logic [10:0]   cmd_vlen;
    logic          vrf_rd_en;
    logic [6:0]    vrf_rd_addr1;
    logic [6:0]    vrf_rd_addr2;
    logic [RW-1:0] vrf_rd_data1;
    logic [RW-1:0] vrf_rd_data2;
    logic          op_valid;
    logic          op_ready;
    logic [RW-1:0] op_a;
    logic [RW-1:0] op_b;
    logic [NB-1:0] op_lane_mask;
    logic          op_last;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int ncap = 0;
    int outstanding = 0;
    logic [RW-1:0] cap_a [16];
    logic [RW-1:0] cap_b [16];
    logic [NB-1:0] cap_mask [16];
    logic          cap_last [16];

    vrf_operand_fetch dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_src1_row (cmd_src1_row),
        .cmd_src2_row (cmd_src2_row),
        .cmd_vlen     (cmd_vlen),
        .vrf_rd_en    (vrf_rd_en),
        .vrf_rd_addr1 (vrf_rd_addr1),
        .vrf_rd_addr2 (vrf_rd_addr2),
        .vrf_rd_data1 (vrf_rd_data1),
        .vrf_rd_data2 (vrf_rd_data2),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_lane_mask (op_lane_mask),
        .op_last      (op_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Unique content for every (port, row, lane).
    function automatic logic [RW-1:0] row_pat(input logic [7:0] port, input logic [6:0] row);
        logic [RW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*DW +: DW] = {port, 1'b0, row, 8'h5A, 8'(i)};
        return r;
    endfunction

    // VRF read ports: data valid the cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (vrf_rd_en) begin
            vrf_rd_data1 <= row_pat(8'h01, vrf_rd_addr1);
            vrf_rd_data2 <= row_pat(8'h02, vrf_rd_addr2);
        end else begin
            vrf_rd_data1 <= {NB{32'hDEADBEEF}};
            vrf_rd_data2 <= {NB{32'hDEADBEEF}};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record accepted beats, advance, then check read credit.
    task automatic step();
        logic iss;
        logic pp;
        iss = vrf_rd_en;
        pp  = op_valid && op_ready;
        if (pp && ncap < 16) begin
            cap_a[ncap]    = op_a;
            cap_b[ncap]    = op_b;
            cap_mask[ncap] = op_lane_mask;
            cap_last[ncap] = op_last;
            ncap++;
        end
        @(posedge clk);
        #1;
        if (!rstn) outstanding = 0;
        else       outstanding = outstanding + int'(iss) - int'(pp);
        chk("credit", RW'(outstanding <= 2), RW'(1));
    endtask

    task automatic send_cmd(input logic [6:0] s1, input logic [6:0] s2, input logic [10:0] vl);
        cmd_valid    = 1'b1;
        cmd_src1_row = s1;
        cmd_src2_row = s2;
        cmd_vlen     = vl;
        chk("cmd_ready_at_accept", RW'(cmd_ready), RW'(1));
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && !(cmd_ready && !op_valid); i++) step();
        chk("idle_reached", RW'(cmd_ready && !op_valid), RW'(1));
    endtask

    task automatic check_beats(input logic [6:0] s1, input logic [6:0] s2, input int nb,
                               input logic [NB-1:0] lm);
        logic [6:0] r1;
        logic [6:0] r2;
        chk("beat_count", RW'(ncap), RW'(nb));
        for (int k = 0; k < nb && k < ncap && k < 16; k++) begin
            r1 = s1 + 7'(k);
            r2 = s2 + 7'(k);
            chk("beat_a", cap_a[k], row_pat(8'h01, r1));
            chk("beat_b", cap_b[k], row_pat(8'h02, r2));
            chk("beat_mask", RW'(cap_mask[k]), RW'((k == nb - 1) ? lm : 8'hFF));
            chk("beat_last", RW'(cap_last[k]), RW'(k == nb - 1));
        end
    endtask

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_src1_row = '0; cmd_src2_row = '0;
        cmd_vlen = '0; op_ready = 1'b1;
        #1;
        step();
        step();
        chk("rst_cmd_ready", RW'(cmd_ready), RW'(1));
        chk("rst_rd_en", RW'(vrf_rd_en), RW'(0));
        chk("rst_addr1", RW'(vrf_rd_addr1), RW'(0));
        chk("rst_addr2", RW'(vrf_rd_addr2), RW'(0));
        chk("rst_op_valid", RW'(op_valid), RW'(0));
        chk("rst_op_a", op_a, '0);
        chk("rst_op_b", op_b, '0);
        chk("rst_mask", RW'(op_lane_mask), RW'(0));
        chk("rst_last", RW'(op_last), RW'(0));
        chk("rst_busy", RW'(busy), RW'(0));
        rstn = 1'b1;
        step();

        // vlen=16 from rows 0/64: exact cycle-by-cycle latency
        ncap = 0;
        send_cmd(7'd0, 7'd64, 11'd16);
        chk("t1_c1_rd_en", RW'(vrf_rd_en), RW'(1));
        chk("t1_c1_addr1", RW'(vrf_rd_addr1), RW'(0));
        chk("t1_c1_addr2", RW'(vrf_rd_addr2), RW'(64));
        chk("t1_c1_op_valid", RW'(op_valid), RW'(0));
        chk("t1_c1_busy", RW'(busy), RW'(1));
        chk("t1_c1_cmd_ready", RW'(cmd_ready), RW'(0));
        step();
        chk("t1_c2_rd_en", RW'(vrf_rd_en), RW'(1));
        chk("t1_c2_addr1", RW'(vrf_rd_addr1), RW'(1));
        chk("t1_c2_addr2", RW'(vrf_rd_addr2), RW'(65));
        chk("t1_c2_op_valid", RW'(op_valid), RW'(1));
        chk("t1_c2_op_a", op_a, row_pat(8'h01, 7'd0));
        chk("t1_c2_op_b", op_b, row_pat(8'h02, 7'd64));
        chk("t1_c2_last", RW'(op_last), RW'(0));
        step();
        chk("t1_c3_rd_en", RW'(vrf_rd_en), RW'(0));
        chk("t1_c3_op_valid", RW'(op_valid), RW'(1));
        chk("t1_c3_op_a", op_a, row_pat(8'h01, 7'd1));
        chk("t1_c3_last", RW'(op_last), RW'(1));
        step();
        chk("t1_c4_op_valid", RW'(op_valid), RW'(0));
        wait_idle();
        check_beats(7'd0, 7'd64, 2, 8'hFF);

        // vlen=11: partial tail beat
        ncap = 0;
        send_cmd(7'd5, 7'd9, 11'd11);
        wait_idle();
        check_beats(7'd5, 7'd9, 2, 8'h07);

        // vlen=24 across the row wrap
        ncap = 0;
        send_cmd(7'd126, 7'd127, 11'd24);
        wait_idle();
        check_beats(7'd126, 7'd127, 3, 8'hFF);

        // vlen=64 with toggling ready and a 5-cycle stall
        ncap = 0;
        send_cmd(7'd10, 7'd20, 11'd64);
        for (int i = 0; i < 30; i++) begin
            if (i >= 10 && i < 15) begin
                op_ready = 1'b0;
                chk("t4_stall_valid", RW'(op_valid), RW'(1));
                chk("t4_stall_a", op_a, row_pat(8'h01, 7'd10 + 7'(ncap)));
                chk("t4_stall_b", op_b, row_pat(8'h02, 7'd20 + 7'(ncap)));
                chk("t4_stall_mask", RW'(op_lane_mask), RW'(8'hFF));
            end else begin
                op_ready = ((i % 2) == 1);
            end
            step();
        end
        op_ready = 1'b1;
        wait_idle();
        check_beats(7'd10, 7'd20, 8, 8'hFF);

        // vlen=0 emits nothing
        send_cmd(7'd3, 7'd3, 11'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_zero_rd_en", RW'(vrf_rd_en), RW'(0));
            chk("t5_zero_op_valid", RW'(op_valid), RW'(0));
            chk("t5_zero_cmd_ready", RW'(cmd_ready), RW'(1));
            step();
        end

        // cmd_valid held through a vlen=32 command with a second command waiting
        ncap = 0;
        cmd_valid = 1'b1; cmd_src1_row = 7'd40; cmd_src2_row = 7'd50; cmd_vlen = 11'd32;
        step();
        cmd_src1_row = 7'd100; cmd_src2_row = 7'd110; cmd_vlen = 11'd8;
        chk("t5_busy", RW'(busy), RW'(1));
        chk("t5_cmd_ready_busy", RW'(cmd_ready), RW'(0));
        for (int i = 0; i < 100 && !cmd_ready; i++) step();
        chk("t5_back_idle", RW'(cmd_ready), RW'(1));
        check_beats(7'd40, 7'd50, 4, 8'hFF);
        ncap = 0;
        step();
        cmd_valid = 1'b0;
        wait_idle();
        check_beats(7'd100, 7'd110, 1, 8'hFF);

        // reset while beat 3 of a vlen=64 command is presented
        ncap = 0;
        send_cmd(7'd30, 7'd60, 11'd64);
        step();
        step();
        step();
        chk("t6_beat3_valid", RW'(op_valid), RW'(1));
        chk("t6_beat3_a", op_a, row_pat(8'h01, 7'd32));
        rstn = 1'b0;
        step();
        chk("t6_rst_op_valid", RW'(op_valid), RW'(0));
        chk("t6_rst_busy", RW'(busy), RW'(0));
        chk("t6_rst_cmd_ready", RW'(cmd_ready), RW'(1));
        chk("t6_rst_rd_en", RW'(vrf_rd_en), RW'(0));
        chk("t6_rst_op_a", op_a, '0);
        chk("t6_rst_mask", RW'(op_lane_mask), RW'(0));
        chk("t6_rst_last", RW'(op_last), RW'(0));
        rstn = 1'b1;
        step();
        chk("t6_post_valid0", RW'(op_valid), RW'(0));
        step();
        chk("t6_post_valid1", RW'(op_valid), RW'(0));
        ncap = 0;
        send_cmd(7'd3, 7'd4, 11'd8);
        wait_idle();
        check_beats(7'd3, 7'd4, 1, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vrf_operand_fetch.md
Name: vrf_operand_fetch

Overview:
- Read-side initiator for the 8-bank vector register file (8 banks x 128 rows x 32 bit).
- Accepts one vector-operand command (src1 row, src2 row, vector length) and walks the VRF row by row, one row across all 8 banks per beat.
- Streams paired operand beats (8 lanes each for A and B) to the execution lanes over a valid/ready interface, with a lane mask on the final partial beat.
- Sits between the vector issue logic and the lane ALUs; the VRF supplies two read ports with 1-cycle synchronous read latency.

Parameters:
- NUM_BANKS, 8, banks = lanes per beat (power of 2)
- DATA_W, 32, element width
- ROW_AW, 7, row address width (128 rows per bank)
- VLEN_W, 11, vector length width (0..1024 elements)
- BUF_DEPTH, 2, output buffer entries (fixed at 2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle and able to accept a command
- cmd_src1_row  in  ROW_AW  starting row of operand A
- cmd_src2_row  in  ROW_AW  starting row of operand B
- cmd_vlen  in  VLEN_W  element count
- vrf_rd_en  out  1  read strobe to both VRF read ports
- vrf_rd_addr1  out  ROW_AW  row for port 1 (operand A)
- vrf_rd_addr2  out  ROW_AW  row for port 2 (operand B)
- vrf_rd_data1  in  NUM_BANKS*DATA_W  port 1 row data, bank0 at LSBs, valid the cycle after vrf_rd_en
- vrf_rd_data2  in  NUM_BANKS*DATA_W  port 2 row data, same format
- op_valid  out  1  operand beat available
- op_ready  in  1  lanes accept beat
- op_a  out  NUM_BANKS*DATA_W  operand A beat
- op_b  out  NUM_BANKS*DATA_W  operand B beat
- op_lane_mask  out  NUM_BANKS  bit i = lane i holds a live element
- op_last  out  1  final beat of the command
- busy  out  1  command in progress (FSM not IDLE)

Behaviour:
- Element mapping: element e sits in bank e mod 8, row (start_row + e/8) mod 128. Beats = ceil(vlen/8).
- Reset (rstn=0 at a clock edge): FSM to IDLE; buffer and in-flight flag cleared. Outputs: cmd_ready=1, vrf_rd_en=0, addrs=0, op_valid=0, op_a/op_b=0, op_lane_mask=0, op_last=0, busy=0.
- Reset mid-command aborts the command: no further beats, in-flight read data discarded.
- FSM states:
  - IDLE: cmd_ready=1. cmd_valid&&cmd_ready latches rows and vlen. vlen=0 stays in IDLE and emits nothing; otherwise go to FETCH.
  - FETCH: issue one read per cycle when credit allows. After the last beat is issued, go to DRAIN.
  - DRAIN: wait until the buffer is empty and nothing is in flight, then return to IDLE. cmd_ready is asserted only in IDLE.
- Credit rule: issue in cycle t iff (buf_count + inflight - pop_t) < BUF_DEPTH, where pop_t = op_valid&&op_ready. Full-throughput streaming holds with op_ready held high.
- Row counters increment by 1 per issued beat and wrap 127 -> 0 (ROW_AW-bit modulo).
- Latency: cmd accept at cycle 0, first vrf_rd_en at cycle 1, first op_valid at cycle 2.
- The cycle after vrf_rd_en, read data is pushed into the 2-entry FIFO together with its mask and last flag. Push and pop in the same cycle are allowed, at full or empty.
- Lane mask: all ones except on the last beat, where it is (1<<r)-1 with r = vlen mod 8; r=0 gives all ones. Masked lanes still carry raw row data.
- op_last=1 exactly on the final beat.
- Output hold: while op_valid && !op_ready, op_a, op_b, op_lane_mask and op_last hold stable.
- cmd_valid outside IDLE is ignored.

Decomposition:
- Shared package vpu_pkg holds NUM_BANKS, DATA_W, ROW_AW, VLEN_W, the fsm state enum {IDLE, FETCH, DRAIN}, and a beat struct {a, b, mask, last}.
- One sub-module, vpu_beat_fifo: 2-entry FIFO of beat structs with push, pop, count, full and empty.

Test Plan:
- vlen=16, src1=0, src2=64, op_ready=1 -> addrs (0,64),(1,65); 2 beats on consecutive cycles; masks 0xFF,0xFF; op_last on beat 2; op_valid first at cycle 2.
- vlen=11, src1=5 -> 2 beats, rows 5,6; mask 0xFF then 0x07; op_last on beat 2.
- vlen=24, src1=126, src2=127 -> rows 126,127,0 and 127,0,1 (wrap); 3 beats.
- vlen=64, op_ready toggled 1/0 per cycle plus a 5-cycle stall -> exactly 8 beats in order, no loss or duplication, data stable during stall, vrf_rd_en never exceeds credit.
- vlen=0 -> no vrf_rd_en, no op_valid, cmd_ready stays 1; then cmd_valid held during a vlen=32 command -> second command ignored until IDLE.
- rstn=0 during beat 3 of vlen=64 -> next cycle op_valid=0, busy=0, cmd_ready=1; a new vlen=8 command then runs cleanly, 1 beat, mask 0xFF.
